// File: rtl/global_avg_pool.sv
// Per-channel global average over POINTS samples of a channel-interleaved stream; one average per channel.
// Latency: first average valid 2 cycles after the frame's last input, then 2 cycles per channel after each handshake.
// Backpressure: input stalls (in_ready=0) from the frame's last sample until done; each output holds until out_ready.
module global_avg_pool #(
    parameter int DATA_W   = 32,
    parameter int CHANNELS = 8,
    parameter int POINTS   = 49,
    parameter int FRAC     = 16,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]          out_channel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     done
);

    localparam int RECIP = ((2 ** FRAC) + POINTS - 1) / POINTS;
    localparam int ACC_W = DATA_W + $clog2(POINTS);
    localparam int PT_W  = (POINTS > 1) ? $clog2(POINTS) : 1;
    localparam int R_W   = FRAC + 2;
    localparam int P_W   = ACC_W + R_W;

    localparam logic [CH_W-1:0]         CH_LAST = CH_W'(CHANNELS - 1);
    localparam logic [PT_W-1:0]         PT_LAST = PT_W'(POINTS - 1);
    localparam logic signed [R_W-1:0]   RECIP_S = R_W'(RECIP);
    localparam logic signed [DATA_W-1:0] DMAX   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] DMIN   = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [P_W-1:0]   PMAX    = P_W'(DMAX);
    localparam logic signed [P_W-1:0]   PMIN    = P_W'(DMIN);

    typedef enum logic [1:0] {ACCUM, CALC, VALID, DONE} state_t;

    state_t                    state, state_n;
    logic signed [ACC_W-1:0]   acc [CHANNELS];
    logic [CH_W-1:0]           ch_cnt;
    logic [CH_W-1:0]           k;
    logic [PT_W-1:0]           pt_cnt;
    logic                      last_q;
    logic                      accept;
    logic                      last_sample;
    logic                      k_last;
    logic                      out_fire;
    logic signed [P_W-1:0]     prod;
    logic signed [P_W-1:0]     quot;
    logic signed [DATA_W-1:0]  avg_sat;

    assign accept      = in_valid && in_ready;
    assign out_fire    = out_valid && out_ready;
    assign last_sample = (ch_cnt == CH_LAST) && (pt_cnt == PT_LAST);
    assign k_last      = (k == CH_LAST);
    assign out_last    = out_valid && last_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ACCUM;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && last_sample) begin
                    state_n = CALC;
                end
            end
            CALC: begin
                state_n = VALID;
            end
            VALID: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_n = k_last ? DONE : CALC;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_n = ACCUM;
            end
            default: state_n = ACCUM;
        endcase
    end

    // Division by POINTS as a multiply by the rounded-up reciprocal; the shift floors toward -inf.
    always_comb begin
        prod = P_W'(acc[k]) * P_W'(RECIP_S);
        quot = prod >>> FRAC;
        if (quot > PMAX) begin
            avg_sat = DMAX;
        end else if (quot < PMIN) begin
            avg_sat = DMIN;
        end else begin
            avg_sat = quot[DATA_W-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i] <= '0;
            end
            ch_cnt      <= '0;
            pt_cnt      <= '0;
            k           <= '0;
            out_data    <= '0;
            out_channel <= '0;
            last_q      <= 1'b0;
        end else begin
            if (accept) begin
                acc[ch_cnt] <= acc[ch_cnt] + ACC_W'(in_data);
                if (ch_cnt == CH_LAST) begin
                    ch_cnt <= '0;
                    pt_cnt <= (pt_cnt == PT_LAST) ? '0 : pt_cnt + PT_W'(1);
                end else begin
                    ch_cnt <= ch_cnt + CH_W'(1);
                end
                if (last_sample) begin
                    k <= '0;
                end
            end
            if (state == CALC) begin
                out_data    <= avg_sat;
                out_channel <= k;
                last_q      <= k_last;
            end
            // The final handshake leaves everything zeroed so the next frame starts clean.
            if (out_fire) begin
                if (!k_last) begin
                    k <= k + CH_W'(1);
                end else begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        acc[i] <= '0;
                    end
                    ch_cnt <= '0;
                    pt_cnt <= '0;
                    k      <= '0;
                end
            end
        end
    end

endmodule
